// File: rtl/dht11_reader_if.sv
// Host-side handshake and result bundle for the DHT11 reader.
// The master requests reads; the slave (reader) reports status and the last good frame bytes.
interface dht11_reader_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic       err_checksum;
    logic [7:0] humidity;
    logic [7:0] hum_dec;
    logic [7:0] temperature;
    logic [7:0] temp_dec;

    modport master (
        output start,
        input  busy, done, err_timeout, err_checksum,
        input  humidity, hum_dec, temperature, temp_dec
    );

    modport slave (
        input  start,
        output busy, done, err_timeout, err_checksum,
        output humidity, hum_dec, temperature, temp_dec
    );
endinterface

// File: rtl/dht11_reader.sv
// DHT11 single-wire host: issues the start pulse, decodes the 40-bit frame, verifies the
// checksum and holds the last good humidity/temperature bytes.
module dht11_reader #(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned START_MS    = 18,
    parameter int unsigned TIMEOUT_US  = 200,
    parameter int unsigned THRESH_US   = 40
) (
    input  logic          hclk,
    input  logic          rst,
    input  logic          dht_in,
    output logic          dht_oe,
    dht11_reader_if.slave host
);
    localparam int unsigned Div     = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned StartUs = START_MS * 1000;
    localparam int unsigned MaxUs   = (StartUs > TIMEOUT_US) ? StartUs : TIMEOUT_US;
    localparam int unsigned CntW    = $clog2(MaxUs + 1) + 1;
    localparam int unsigned PreW    = (Div > 1) ? $clog2(Div) : 1;

    typedef enum logic [3:0] {
        StIdle, StStartLow, StWaitResp, StRespLow, StRespHigh,
        StBitLow, StBitHigh, StCheck, StDone
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, dly_q;
    logic            rise, fall;
    logic [PreW-1:0] pre_q, pre_d;
    logic            us_tick;
    logic [CntW-1:0] us_q, us_d;
    logic [5:0]      idx_q, idx_d;
    logic [39:0]     frame_q, frame_d;
    logic            err_to_q, err_to_d, err_cs_q, err_cs_d;
    logic [7:0]      hum_q, hum_d, hdec_q, hdec_d, tmp_q, tmp_d, tdec_q, tdec_d;
    logic [7:0]      sum;
    logic            timeout, bit_val, wait_state;

    assign rise    = sync2_q & ~dly_q;
    assign fall    = ~sync2_q & dly_q;
    assign us_tick = (pre_q == PreW'(Div - 1));
    assign timeout = us_tick && (us_q >= CntW'(TIMEOUT_US - 1));
    // us_q lags the true high time by one, so compare against THRESH_US-1
    assign bit_val = (us_q >= CntW'(THRESH_US - 1));
    assign sum     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    assign wait_state = (state_q == StWaitResp) || (state_q == StRespLow) ||
                        (state_q == StRespHigh) || (state_q == StBitLow) ||
                        (state_q == StBitHigh);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        err_to_d = err_to_q;
        err_cs_d = err_cs_q;
        hum_d    = hum_q;
        hdec_d   = hdec_q;
        tmp_d    = tmp_q;
        tdec_d   = tdec_q;
        pre_d    = us_tick ? '0 : pre_q + 1'b1;
        us_d     = (us_tick && us_q != '1) ? us_q + 1'b1 : us_q;

        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    err_to_d = 1'b0;
                    err_cs_d = 1'b0;
                    state_d  = StStartLow;
                end
            end
            StStartLow: if (us_tick && us_q >= CntW'(StartUs - 1)) state_d = StWaitResp;
            StWaitResp: if (fall) state_d = StRespLow;
            StRespLow:  if (rise) state_d = StRespHigh;
            StRespHigh: begin
                if (fall) begin
                    idx_d   = 6'd0;
                    state_d = StBitLow;
                end
            end
            StBitLow:   if (rise) state_d = StBitHigh;
            StBitHigh: begin
                if (fall) begin
                    frame_d = {frame_q[38:0], bit_val};
                    if (idx_q == 6'd39) begin
                        state_d = StCheck;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = StBitLow;
                    end
                end
            end
            StCheck: begin
                if (sum == frame_q[7:0]) begin
                    hum_d  = frame_q[39:32];
                    hdec_d = frame_q[31:24];
                    tmp_d  = frame_q[23:16];
                    tdec_d = frame_q[15:8];
                end else begin
                    err_cs_d = 1'b1;
                end
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // An edge that arrives on the same tick as the timeout still wins
        if (wait_state && timeout && state_d == state_q) begin
            err_to_d = 1'b1;
            state_d  = StDone;
        end

        if (state_d != state_q) begin
            us_d  = '0;
            pre_d = '0;
        end
    end

    always_ff @(posedge hclk) begin
        if (rst) begin
            state_q  <= StIdle;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            dly_q    <= 1'b1;
            pre_q    <= '0;
            us_q     <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            err_to_q <= 1'b0;
            err_cs_q <= 1'b0;
            hum_q    <= '0;
            hdec_q   <= '0;
            tmp_q    <= '0;
            tdec_q   <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= dht_in;
            sync2_q  <= sync1_q;
            dly_q    <= sync2_q;
            pre_q    <= pre_d;
            us_q     <= us_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            err_to_q <= err_to_d;
            err_cs_q <= err_cs_d;
            hum_q    <= hum_d;
            hdec_q   <= hdec_d;
            tmp_q    <= tmp_d;
            tdec_q   <= tdec_d;
        end
    end

    assign dht_oe            = (state_q == StStartLow);
    assign host.busy         = (state_q != StIdle) && (state_q != StDone);
    assign host.done         = (state_q == StDone);
    assign host.err_timeout  = err_to_q;
    assign host.err_checksum = err_cs_q;
    assign host.humidity     = hum_q;
    assign host.hum_dec      = hdec_q;
    assign host.temperature  = tmp_q;
    assign host.temp_dec     = tdec_q;
endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader at 1 MHz (1 cycle = 1 us) with a behavioural sensor model.
module tb_dht11_reader;
    logic hclk = 1'b0;
    logic rst = 1'b1;
    logic sensor = 1'b1;
    logic dht_in;
    logic dht_oe;
    int   total = 0;
    int   bad = 0;

    dht11_reader_if host ();

    dht11_reader #(
        .CLK_FREQ_HZ(1_000_000),
        .START_MS   (1),
        .TIMEOUT_US (200),
        .THRESH_US  (40)
    ) dut (
        .hclk  (hclk),
        .rst   (rst),
        .dht_in(dht_in),
        .dht_oe(dht_oe),
        .host  (host)
    );

    always #5 hclk = ~hclk;

    // Open-drain line with pull-up
    assign dht_in = sensor & ~dht_oe;

    typedef struct {
        logic [39:0] bits;
        int          hi0;
        int          hi1;
        bit          mid_start;
        logic [7:0]  e_hum;
        logic [7:0]  e_hdec;
        logic [7:0]  e_tmp;
        logic [7:0]  e_tdec;
        logic        e_cs;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sensor_frame(input logic [39:0] bits, input int hi0, input int hi1);
        int n = 0;
        while (!dht_oe && n < 100) begin @(negedge hclk); n++; end
        while (dht_oe && n < 5000) begin @(negedge hclk); n++; end
        repeat (30) @(negedge hclk);
        sensor = 1'b0; repeat (80) @(negedge hclk);
        sensor = 1'b1; repeat (80) @(negedge hclk);
        for (int i = 39; i >= 0; i--) begin
            sensor = 1'b0; repeat (50) @(negedge hclk);
            sensor = 1'b1; repeat (bits[i] ? hi1 : hi0) @(negedge hclk);
        end
        sensor = 1'b0; repeat (50) @(negedge hclk);
        sensor = 1'b1;
    endtask

    task automatic run_txn(input logic [39:0] bits, input int hi0, input int hi1,
                           input bit respond, input bit mid_start,
                           output int oe_cyc, output int done_cnt, output int rel_to_done);
        oe_cyc = 0;
        done_cnt = 0;
        rel_to_done = -1;
        fork
            if (respond) sensor_frame(bits, hi0, hi1);
            begin
                int  cyc = 0;
                int  rel = -1;
                int  post = 0;
                bit  prev_oe = 1'b0;
                bit  seen = 1'b0;
                @(negedge hclk);
                host.start = 1'b1;
                while (cyc < 20000 && post < 5) begin
                    @(negedge hclk);
                    cyc++;
                    if (cyc == 1) host.start = 1'b0;
                    if (mid_start && cyc == 1500) host.start = 1'b1;
                    if (mid_start && cyc == 1501) host.start = 1'b0;
                    if (dht_oe) oe_cyc++;
                    if (prev_oe && !dht_oe) rel = cyc;
                    prev_oe = dht_oe;
                    if (host.done) begin
                        done_cnt++;
                        if (rel >= 0) rel_to_done = cyc - rel;
                        seen = 1'b1;
                    end
                    if (seen) post++;
                end
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oe_cyc, done_cnt, rel;

        vecs[0] = '{40'h3700190050, 27, 70, 1'b0, 8'h37, 8'h00, 8'h19, 8'h00, 1'b0};
        vecs[1] = '{40'h3700190051, 27, 70, 1'b0, 8'h37, 8'h00, 8'h19, 8'h00, 1'b1};
        vecs[2] = '{40'h8080808000, 27, 70, 1'b0, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0};
        vecs[3] = '{40'h3700190050, 39, 41, 1'b1, 8'h37, 8'h00, 8'h19, 8'h00, 1'b0};

        host.start = 1'b0;
        repeat (3) @(negedge hclk);
        check("rst_oe", dht_oe, 0);
        check("rst_busy", host.busy, 0);
        check("rst_done", host.done, 0);
        check("rst_err_to", host.err_timeout, 0);
        check("rst_err_cs", host.err_checksum, 0);
        check("rst_data", {host.humidity, host.hum_dec, host.temperature, host.temp_dec}, 0);
        rst = 1'b0;
        repeat (5) @(negedge hclk);

        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v].bits, vecs[v].hi0, vecs[v].hi1, 1'b1, vecs[v].mid_start,
                    oe_cyc, done_cnt, rel);
            check($sformatf("v%0d_oe_cycles", v), oe_cyc, 1000);
            check($sformatf("v%0d_done_count", v), done_cnt, 1);
            check($sformatf("v%0d_err_to", v), host.err_timeout, 0);
            check($sformatf("v%0d_err_cs", v), host.err_checksum, vecs[v].e_cs);
            check($sformatf("v%0d_humidity", v), host.humidity, vecs[v].e_hum);
            check($sformatf("v%0d_hum_dec", v), host.hum_dec, vecs[v].e_hdec);
            check($sformatf("v%0d_temperature", v), host.temperature, vecs[v].e_tmp);
            check($sformatf("v%0d_temp_dec", v), host.temp_dec, vecs[v].e_tdec);
            repeat (20) @(negedge hclk);
        end

        // No sensor: line stays high after release
        run_txn(40'h0, 27, 70, 1'b0, 1'b0, oe_cyc, done_cnt, rel);
        check("to_done_count", done_cnt, 1);
        check("to_latency_in_199_201", (rel >= 199 && rel <= 201), 1);
        check("to_err_to", host.err_timeout, 1);
        check("to_busy", host.busy, 0);
        check("to_oe", dht_oe, 0);
        check("to_humidity_kept", host.humidity, 8'h37);
        repeat (20) @(negedge hclk);

        // Reset while the first data bit is high
        fork
            sensor_frame(40'h3700190050, 27, 70);
            begin
                @(negedge hclk);
                host.start = 1'b1;
                @(negedge hclk);
                host.start = 1'b0;
                repeat (1254) @(negedge hclk);
                check("mid_busy_before_rst", host.busy, 1);
                rst = 1'b1;
                @(negedge hclk);
                check("mid_rst_oe", dht_oe, 0);
                check("mid_rst_busy", host.busy, 0);
                check("mid_rst_data",
                      {host.humidity, host.hum_dec, host.temperature, host.temp_dec}, 0);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge hclk);

        run_txn(40'h3700190050, 27, 70, 1'b1, 1'b0, oe_cyc, done_cnt, rel);
        check("post_rst_done_count", done_cnt, 1);
        check("post_rst_err_cs", host.err_checksum, 0);
        check("post_rst_humidity", host.humidity, 8'h37);
        check("post_rst_temperature", host.temperature, 8'h19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
